// File: rtl/ctrl_spi_tx_if.sv
// ctrl_spi_tx_if: request/status handshake and SPI pins of the control-frame transmitter
interface ctrl_spi_tx_if;
    logic [15:0] data0;
    logic [15:0] data1;
    logic        send;
    logic        busy;
    logic        done;
    logic        spi_nss;
    logic        spi_clock;
    logic        spi_data;
    modport master (
        output data0, data1, send,
        input  busy, done, spi_nss, spi_clock, spi_data
    );
    modport slave (
        input  data0, data1, send,
        output busy, done, spi_nss, spi_clock, spi_data
    );
endinterface

// File: rtl/ctrl_spi_tx.sv
// ctrl_spi_tx: SPI mode-0 master sending one 32-bit frame {data0, data1}, MSB first
module ctrl_spi_tx #(
    parameter int unsigned CLK_DIV      = 4,
    parameter int unsigned SETUP_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES  = 4,
    parameter int unsigned GAP_CYCLES   = 8
) (
    input  logic          fpga_clock,
    input  logic          reset,
    ctrl_spi_tx_if.slave  bus
);
    localparam int unsigned MAX_A   = CLK_DIV > SETUP_CYCLES ? CLK_DIV : SETUP_CYCLES;
    localparam int unsigned MAX_B   = HOLD_CYCLES > GAP_CYCLES ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned MAX_CNT = MAX_A > MAX_B ? MAX_A : MAX_B;
    localparam int unsigned PW      = $clog2(MAX_CNT + 1);
    typedef logic [PW-1:0] phase_t;
    localparam phase_t DIV_LAST   = phase_t'(CLK_DIV - 1);
    localparam phase_t SETUP_LAST = phase_t'(SETUP_CYCLES - 1);
    localparam phase_t HOLD_LAST  = phase_t'(HOLD_CYCLES - 1);
    localparam phase_t GAP_LAST   = phase_t'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SCK_HIGH, SCK_LOW, HOLD, GAP} state_t;

    state_t      state, state_n;
    phase_t      phase, phase_n, limit;
    logic [4:0]  bit_cnt, bit_n;
    logic [31:0] shift, shift_n;
    logic        nss, nss_n, sck, sck_n, busy, busy_n, done, done_n, wrap;

    always_comb begin
        limit = state == SETUP ? SETUP_LAST :
                state == HOLD  ? HOLD_LAST  :
                state == GAP   ? GAP_LAST   : DIV_LAST;
        wrap = phase == limit;
    end

    // MOSI is shift[31]; the 32nd shift empties the register, so MOSI is 0 after fall 31 and while idle
    always_comb begin
        state_n = state;
        phase_n = wrap ? '0 : phase + phase_t'(1);
        bit_n   = bit_cnt;
        shift_n = shift;
        nss_n   = nss;
        sck_n   = sck;
        busy_n  = busy;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                phase_n = '0;
                if (bus.send) begin
                    shift_n = {bus.data0, bus.data1};
                    bit_n   = '0;
                    nss_n   = 1'b0;
                    busy_n  = 1'b1;
                    state_n = SETUP;
                end
            end
            SETUP: if (wrap) begin
                sck_n   = 1'b1;
                state_n = SCK_HIGH;
            end
            SCK_HIGH: if (wrap) begin
                sck_n   = 1'b0;
                shift_n = {shift[30:0], 1'b0};
                state_n = bit_cnt == 5'd31 ? HOLD : SCK_LOW;
            end
            SCK_LOW: if (wrap) begin
                sck_n   = 1'b1;
                bit_n   = bit_cnt + 5'd1;
                state_n = SCK_HIGH;
            end
            HOLD: if (wrap) begin
                nss_n   = 1'b1;
                state_n = GAP;
            end
            GAP: if (wrap) begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge fpga_clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            phase   <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            nss     <= 1'b1;
            sck     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            phase   <= phase_n;
            bit_cnt <= bit_n;
            shift   <= shift_n;
            nss     <= nss_n;
            sck     <= sck_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

    assign bus.spi_nss   = nss;
    assign bus.spi_clock = sck;
    assign bus.spi_data  = shift[31];
    assign bus.busy      = busy;
    assign bus.done      = done;
endmodule
